uart_tx_buffered: RTL and testbench

//  Buffered 8N1 UART transmitter. It is the transmit-side counterpart of the board's serial receiver.
//  The processor's memory map pushes bytes into an internal FIFO, and the block serialises them onto serialOut.

---
 rtl/uart_tx_buffered.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter, LSB first, idle-high line.
// Default frame is 8N1. Defining UART_TX_PARITY_EN switches to 8E1, which adds
// one even-parity bit between data bit 7 and the stop bit.
// Bytes pushed with wr_en are queued in a FIFO_DEPTH-entry FIFO. When another
// byte is waiting, the next frame starts straight after the stop bit.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [7:0]                      wr_data,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic                            busy,
    output logic                            serialOut
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity over one data byte: the transmitted bit makes the total count of ones even.
    function automatic logic even_parity8(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    // FIFO storage and occupancy
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_overflow;

    // Transmit engine
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_serial;
    logic          r_busy;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    logic          w_push;
    logic          w_pop;
    logic          w_bit_done;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count_nxt;

    // full is registered from the pre-edge count, so a write while full is dropped
    // even when the engine pops on the same edge.
    assign w_push     = wr_en & ~r_full;
    assign w_bit_done = (r_baud == BAUD_LAST);
    assign w_head     = r_mem[r_rd_ptr];

    assign full       = r_full;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign busy       = r_busy;
    assign serialOut  = r_serial;

    // Pop decision: take a byte when idle, or at the final stop-bit cycle for back-to-back frames.
    always_comb begin
        w_pop = 1'b0;
        if ((r_count != {CW{1'b0}}) &&
            ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done))) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
    end

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO data array: written only on an accepted push. No reset is needed because the pointers guard it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, count, full flag and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == DEPTH_CNT);
            r_overflow <= r_overflow | (wr_en & r_full);
        end
    end

    // Transmit FSM: drives the registered line and busy, and serialises the shift register LSB first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= {BW{1'b0}};
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= {BW{1'b0}};
                    if (w_pop) begin
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= even_parity8(w_head);
`endif
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_START;
                    end else begin
                        r_serial <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_baud    <= {BW{1'b0}};
                        r_bit_idx <= 3'd0;
                        r_serial  <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        r_baud <= {BW{1'b0}};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_serial <= r_parity;
                            r_state  <= ST_PARITY;
`else
                            r_serial <= 1'b1;
                            r_state  <= ST_STOP;
`endif
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_serial  <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_baud   <= {BW{1'b0}};
                        r_serial <= 1'b1;
                        r_state  <= ST_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_done) begin
                        r_baud <= {BW{1'b0}};
                        if (w_pop) begin
                            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= even_parity8(w_head);
`endif
                            r_serial <= 1'b0;
                            r_state  <= ST_START;
                        end else begin
                            r_serial <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud    <= {BW{1'b0}};
                    r_bit_idx <= 3'd0;
                    r_serial  <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Every accepted byte is queued as an expected value. A line monitor decodes
// each frame and checks it against the head of that queue.
module tb_uart_tx_buffered;

    localparam int CPB = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       busy;
    logic       serialOut;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rx_frames = 0;
    int         peak = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int         frame_start[$];

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .fifo_count(fifo_count), .overflow(overflow),
        .busy(busy), .serialOut(serialOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Push one byte on the next edge. The byte joins the expected queue only if it should be accepted.
    task automatic write_byte(input logic [7:0] b, input bit accept);
        wr_en = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Wait, with a cycle bound, until the line is idle and every expected frame has been seen.
    task automatic wait_idle(input int limit);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (!busy && fifo_count == 3'd0 && exp_q.size() == 0) done = 1'b1;
        end
        check_eq("wait_idle_timeout", done, 1);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: samples each bit mid-cell, measured from the first low cycle of the start bit.
    initial begin
        logic [7:0] m_exp;
        logic [7:0] m_got;
        forever begin
            @(negedge clk);
            if (mon_en && serialOut === 1'b0) begin
                frame_start.push_back(cyc);
                check_eq("rx_queue_nonempty", exp_q.size() != 0, 1);
                m_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                repeat (2) @(negedge clk);
                check_eq("rx_start", serialOut, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    m_got[i] = serialOut;
                end
                check_eq("rx_data", m_got, m_exp);
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                check_eq("rx_parity", serialOut, ^m_exp);
`endif
                repeat (CPB) @(negedge clk);
                check_eq("rx_stop", serialOut, 1);
                @(negedge clk);
                rx_frames++;
            end
        end
    end

    initial begin
        logic [10:0] fb;
        int base;
        int rx0;

        // 1. Reset values while reset is held and after release.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_held_line", serialOut, 1);
        check_eq("rst_held_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_line", serialOut, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_overflow", overflow, 0);

        // Assert reset between clock edges in the middle of a start bit.
        write_byte(8'h55, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("pre_reset_line_low", serialOut, 0);
        reset = 1'b1;
        #1;
        check_eq("async_reset_line", serialOut, 1);
        check_eq("async_reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post_reset_count", fifo_count, 0);
        check_eq("post_reset_line", serialOut, 1);
        mon_en = 1'b1;

        // 2. One frame of 0xA5, checked cycle by cycle.
        fb = 11'h7FF;
        fb[0] = 1'b0;
        fb[8:1] = 8'hA5;
`ifdef UART_TX_PARITY_EN
        fb[9] = ^fb[8:1];
`endif
        write_byte(8'hA5, 1'b1);
        @(negedge clk);
        check_eq("latency_still_idle", serialOut, 1);
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge clk);
            check_eq("a5_line", serialOut, fb[c / CPB]);
            check_eq("a5_busy", busy, 1);
        end
        @(negedge clk);
        check_eq("a5_busy_fall", busy, 0);
        check_eq("a5_line_idle", serialOut, 1);
        wait_idle(200);

        // 3. Three consecutive writes produce back-to-back frames.
        base = frame_start.size();
        peak = 0;
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            exp_q.push_back(8'(i));
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        wait_idle(500);
        check_eq("b2b_peak_count", peak, 2);
        check_eq("b2b_frames", frame_start.size() - base, 3);
        if (frame_start.size() >= base + 3) begin
            check_eq("b2b_gap1", frame_start[base+1] - frame_start[base], FRAME_CYC);
            check_eq("b2b_gap2", frame_start[base+2] - frame_start[base+1], FRAME_CYC);
        end
        check_eq("no_overflow_yet", overflow, 0);

        // 4. Overfill the FIFO while the first frame is on the line.
        rx0 = rx_frames;
        write_byte(8'hF0, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            write_byte(8'(8'h10 + i), i < 4);
            check_eq("full_after_write", full, i >= 3);
        end
        check_eq("ovf_count", fifo_count, 4);
        check_eq("ovf_flag", overflow, 1);
        wait_idle(1000);
        check_eq("ovf_frames_sent", rx_frames - rx0, 5);
        check_eq("ovf_sticky", overflow, 1);

        // 5. A write on the same edge as the stop-to-start pop is dropped while full.
        write_byte(8'hA0, 1'b1);
        for (int i = 0; i < 4; i++) write_byte(8'(8'hB0 + i), 1'b1);
        check_eq("pop_edge_pre_count", fifo_count, 4);
        check_eq("pop_edge_pre_full", full, 1);
        repeat (FRAME_CYC - 4) @(posedge clk);
        #1;
        write_byte(8'hEE, 1'b0);
        check_eq("pop_edge_count", fifo_count, 3);
        check_eq("pop_edge_full", full, 0);
        check_eq("pop_edge_next_start", serialOut, 0);
        wait_idle(1000);

`ifdef UART_TX_PARITY_EN
        // 6. Parity values: the monitor checks 0x07 (parity 1) and 0x03 (parity 0).
        write_byte(8'h07, 1'b1);
        write_byte(8'h03, 1'b1);
        wait_idle(500);
`endif

        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
